block_sprite_renderer: RTL and testbench
========================================

// Module: block_sprite_renderer
// PURPOSE
//  Draws the pushable stone block in the pixel pipeline and moves it once per frame.
//  - Motion: a per-frame FSM for push and gravity holds the block's screen position.
//  - Render: for each DrawX/DrawY it fetches the sprite texel from the block sprite ROM.
//  - Output: a 4-bit palette index plus a hit flag, fed straight into block_palette,
//    whose RGB goes to the colour mapper.
// PARAMETERS
//  BOX_SIZE         32    block edge in pixels (power of 2); ROM depth = BOX_SIZE^2
//  X_INIT           304   reset X of the block's top-left corner
//  Y_INIT           224   reset Y of the block's top-left corner
//  X_MIN            0     leftmost legal X
//  X_MAX            640   right screen limit; legal X <= X_MAX-BOX_SIZE
//  Y_MAX            480   bottom limit; legal Y <= Y_MAX-BOX_SIZE
//  PUSH_STEP        1     pixels moved per frame while pushed
//  FALL_STEP        2     pixels dropped per frame while unsupported
//  TRANSPARENT_IDX  4'h6  colour key; texels with this index are not drawn
// PORTS
//  Clk           in   1   pixel clock; the only clock
//  Reset         in   1   synchronous, active-high
//  frame_tick    in   1   1-cycle pulse at start of vertical blank
//  push_left     in   1   level; a player pushes the block leftwards; sampled on frame_tick
//  push_right    in   1   level; a player pushes the block rightwards; sampled on frame_tick
//  floor_below   in   1   level; collision map reports solid directly under the block
//  pixel_valid   in   1   DrawX/DrawY are in the active area this cycle
//  DrawX         in   10  current pixel column
//  DrawY         in   10  current pixel row
//  rom_addr      out  10  sprite ROM address (log2(BOX_SIZE^2) bits), registered
//  rom_data      in   4   sprite ROM read data; synchronous, 1 cycle after rom_addr
//  index         out  4   palette index to block_palette
//  block_hit     out  1   block pixel is opaque and inside; colour mapper selects block
//  out_valid     out  1   index/block_hit correspond to a valid pixel
//  BoxX          out  10  current top-left X, for collision logic
//  BoxY          out  10  current top-left Y, for collision logic
// BEHAVIOUR
//  Reset
//  - Takes effect on the first Clk edge with Reset=1, including mid-frame or mid-fall.
//  - BoxX=X_INIT, BoxY=Y_INIT, state=REST.
//  - Pipeline valid/inside flags clear; rom_addr=0, index=0, block_hit=0, out_valid=0.
//  Motion FSM: states REST, SLIDE_L, SLIDE_R, FALL
//  - Updates only on a Clk edge with frame_tick=1; otherwise BoxX/BoxY/state hold.
//  - On frame_tick the next state is chosen by priority:
//    - !floor_below                -> FALL;    BoxY += FALL_STEP, clamped to Y_MAX-BOX_SIZE
//    - else push_left ^ push_right -> SLIDE_L / SLIDE_R; BoxX -/+ PUSH_STEP,
//      clamped to [X_MIN, X_MAX-BOX_SIZE]
//    - else (both pushes or neither) -> REST; no move
//  - Gravity beats pushes: while falling the block ignores pushes and X does not change.
//  - Landing: floor_below=1 while in FALL -> REST or SLIDE on that tick, Y unchanged.
//  - Clamp arithmetic is 11-bit; no wrap at either screen edge.
//  Render pipeline (fixed latency 2, one pixel per clock, no stalls)
//  - S1, edge after the inputs:
//    - inside = pixel_valid and BoxX <= DrawX < BoxX+BOX_SIZE and BoxY <= DrawY < BoxY+BOX_SIZE
//      (11-bit compares).
//    - rom_addr <= (DrawY-BoxY)*BOX_SIZE + (DrawX-BoxX) when inside; otherwise it holds.
//    - s1_valid <= pixel_valid; s1_inside <= inside.
//  - S2, next edge: s2_valid, s2_inside registered; rom_data is now valid for the S1 address.
//  - Outputs are combinational from the S2 flags and rom_data:
//    - out_valid = s2_valid.
//    - block_hit = s2_valid & s2_inside & (rom_data != TRANSPARENT_IDX).
//    - index = block_hit ? rom_data : 4'h0.
//  - frame_tick on the same edge as a pixel: that pixel uses the old position;
//    all later pixels use the new one.
// STRUCTURE
//  - block_pkg holds:
//    - box_state_t enum {REST, SLIDE_L, SLIDE_R, FALL};
//    - SCREEN_W=640, SCREEN_H=480, COORD_W=10.
//  - Sub-module block_motion_fsm holds the FSM, BoxX/BoxY and clamping.
//  - The top level holds the render pipeline.
// TESTING
//  1. Reset=1 mid-frame, then release -> next cycle BoxX=304, BoxY=224,
//     out_valid=0, block_hit=0, index=0.
//  2. Block at (304,224), drive DrawX=305, DrawY=226, pixel_valid=1 -> rom_addr=65 one
//     cycle later; ROM returns 4'h4 -> index=4, block_hit=1, out_valid=1 two cycles after input.
//  3. Same setup with ROM returning 4'h6 -> block_hit=0, index=0, out_valid=1;
//     DrawX=336 (just past the block) -> block_hit=0.
//  4. floor_below=0 with push_right=1, 3 frame_ticks -> BoxY=230, BoxX=304;
//     then floor_below=1, one tick -> BoxX=305, state SLIDE_R.
//  5. BoxX=1, push_left=1, 3 ticks -> BoxX=0 and holds (clamp);
//     both pushes held -> REST, no move.
//  6. frame_tick pulses between back-to-back pixels at DrawX=303 and 304 -> first pixel
//     uses the old BoxX, the next the new; no glitch on out_valid.

Source files
------------

// File: rtl/block_pkg.sv
// Shared types and screen constants for the pushable stone block.
package block_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int COORD_W  = 10;

  typedef enum logic [1:0] {
    REST    = 2'd0,
    SLIDE_L = 2'd1,
    SLIDE_R = 2'd2,
    FALL    = 2'd3
  } box_state_t;

  // Saturating upper clamp on 11-bit screen arithmetic.
  function automatic logic [COORD_W:0] clamp_hi(input logic [COORD_W:0] v,
                                                input logic [COORD_W:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/block_motion_fsm.sv
// Per-frame push/gravity FSM holding the block's top-left screen position.
module block_motion_fsm
  import block_pkg::*;
#(
  parameter int BOX_SIZE  = 32,
  parameter int X_INIT    = 304,
  parameter int Y_INIT    = 224,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = SCREEN_W,
  parameter int Y_MAX     = SCREEN_H,
  parameter int PUSH_STEP = 1,
  parameter int FALL_STEP = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               push_left,
  input  logic               push_right,
  input  logic               floor_below,
  output logic [COORD_W-1:0] box_x,
  output logic [COORD_W-1:0] box_y
);

  localparam logic [COORD_W:0] X_LO   = (COORD_W+1)'(X_MIN);
  localparam logic [COORD_W:0] X_HI   = (COORD_W+1)'(X_MAX - BOX_SIZE);
  localparam logic [COORD_W:0] Y_HI   = (COORD_W+1)'(Y_MAX - BOX_SIZE);
  localparam logic [COORD_W:0] PSTEP  = (COORD_W+1)'(PUSH_STEP);
  localparam logic [COORD_W:0] FSTEP  = (COORD_W+1)'(FALL_STEP);

  box_state_t         state_r, state_nxt_s;
  logic [COORD_W-1:0] x_r, y_r, x_nxt_s, y_nxt_s;
  logic [COORD_W:0]   x_ext_s, y_ext_s, x_left_s, x_right_s, y_fall_s;

  // Candidate positions for each move, all widened so nothing wraps at an edge.
  always_comb begin
    x_ext_s   = {1'b0, x_r};
    y_ext_s   = {1'b0, y_r};
    y_fall_s  = clamp_hi(y_ext_s + FSTEP, Y_HI);
    x_right_s = clamp_hi(x_ext_s + PSTEP, X_HI);
    if (x_ext_s < X_LO + PSTEP) begin
      x_left_s = X_LO;
    end else begin
      x_left_s = x_ext_s - PSTEP;
    end
  end

  // Next state and position; gravity outranks pushes, and nothing moves off-tick.
  always_comb begin
    state_nxt_s = state_r;
    x_nxt_s     = x_r;
    y_nxt_s     = y_r;
    if (frame_tick) begin
      if (!floor_below) begin
        state_nxt_s = FALL;
        y_nxt_s     = y_fall_s[COORD_W-1:0];
      end else if (push_left ^ push_right) begin
        if (push_left) begin
          state_nxt_s = SLIDE_L;
          x_nxt_s     = x_left_s[COORD_W-1:0];
        end else begin
          state_nxt_s = SLIDE_R;
          x_nxt_s     = x_right_s[COORD_W-1:0];
        end
      end else begin
        state_nxt_s = REST;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State and position registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= REST;
      x_r     <= COORD_W'(X_INIT);
      y_r     <= COORD_W'(Y_INIT);
    end else begin
      state_r <= state_nxt_s;
      x_r     <= x_nxt_s;
      y_r     <= y_nxt_s;
    end
  end

  assign box_x = x_r;
  assign box_y = y_r;

endmodule

// File: rtl/block_sprite_renderer.sv
// Stone-block sprite: motion FSM plus a 2-stage render pipeline into block_palette.
module block_sprite_renderer
  import block_pkg::*;
#(
  parameter int         BOX_SIZE        = 32,
  parameter int         X_INIT          = 304,
  parameter int         Y_INIT          = 224,
  parameter int         X_MIN           = 0,
  parameter int         X_MAX           = SCREEN_W,
  parameter int         Y_MAX           = SCREEN_H,
  parameter int         PUSH_STEP       = 1,
  parameter int         FALL_STEP       = 2,
  parameter logic [3:0] TRANSPARENT_IDX = 4'h6,
  localparam int        ADDR_W          = $clog2(BOX_SIZE * BOX_SIZE),
  localparam int        LOG_B           = $clog2(BOX_SIZE)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_tick,
  input  logic               push_left,
  input  logic               push_right,
  input  logic               floor_below,
  input  logic               pixel_valid,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [3:0]         rom_data,
  output logic [3:0]         index,
  output logic               block_hit,
  output logic               out_valid,
  output logic [COORD_W-1:0] BoxX,
  output logic [COORD_W-1:0] BoxY
);

  logic [COORD_W:0]  dx_ext_s, dy_ext_s, bx_ext_s, by_ext_s, dx_off_s, dy_off_s;
  logic              inside_s;
  logic [ADDR_W-1:0] addr_s, rom_addr_r;
  logic              s1_valid_r, s1_inside_r, s2_valid_r, s2_inside_r;
  logic              hit_s;
  logic [3:0]        index_s;

  block_motion_fsm #(
    .BOX_SIZE (BOX_SIZE),
    .X_INIT   (X_INIT),
    .Y_INIT   (Y_INIT),
    .X_MIN    (X_MIN),
    .X_MAX    (X_MAX),
    .Y_MAX    (Y_MAX),
    .PUSH_STEP(PUSH_STEP),
    .FALL_STEP(FALL_STEP)
  ) u_motion (
    .clk        (Clk),
    .reset      (Reset),
    .frame_tick (frame_tick),
    .push_left  (push_left),
    .push_right (push_right),
    .floor_below(floor_below),
    .box_x      (BoxX),
    .box_y      (BoxY)
  );

  // Hit test against the current (pre-tick) position; offsets become the texel address.
  always_comb begin
    dx_ext_s = {1'b0, DrawX};
    dy_ext_s = {1'b0, DrawY};
    bx_ext_s = {1'b0, BoxX};
    by_ext_s = {1'b0, BoxY};
    dx_off_s = dx_ext_s - bx_ext_s;
    dy_off_s = dy_ext_s - by_ext_s;
    inside_s = pixel_valid
             && (dx_ext_s >= bx_ext_s) && (dx_ext_s < bx_ext_s + (COORD_W+1)'(BOX_SIZE))
             && (dy_ext_s >= by_ext_s) && (dy_ext_s < by_ext_s + (COORD_W+1)'(BOX_SIZE));
    addr_s   = {dy_off_s[LOG_B-1:0], dx_off_s[LOG_B-1:0]};
  end

  // S1/S2 pipeline; the ROM address only moves for pixels inside the block.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid_r  <= 1'b0;
      s1_inside_r <= 1'b0;
      s2_valid_r  <= 1'b0;
      s2_inside_r <= 1'b0;
      rom_addr_r  <= '0;
    end else begin
      s1_valid_r  <= pixel_valid;
      s1_inside_r <= inside_s;
      s2_valid_r  <= s1_valid_r;
      s2_inside_r <= s1_inside_r;
      if (inside_s) begin
        rom_addr_r <= addr_s;
      end else begin
        rom_addr_r <= rom_addr_r;
      end
    end
  end

  // Colour-keyed texels fall through to whatever lies behind the block.
  always_comb begin
    hit_s   = 1'b0;
    index_s = 4'h0;
    if (s2_valid_r && s2_inside_r && (rom_data != TRANSPARENT_IDX)) begin
      hit_s   = 1'b1;
      index_s = rom_data;
    end else begin
      hit_s   = 1'b0;
      index_s = 4'h0;
    end
  end

  assign rom_addr  = rom_addr_r;
  assign out_valid = s2_valid_r;
  assign block_hit = hit_s;
  assign index     = index_s;

endmodule

// File: tb/tb_block_sprite_renderer.sv
// Scoreboard bench for block_sprite_renderer with a behavioural synchronous sprite ROM.
module tb_block_sprite_renderer;
  import block_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0, push_left = 1'b0, push_right = 1'b0, floor_below = 1'b1;
  logic       pixel_valid = 1'b0;
  logic [9:0] DrawX = 10'd0, DrawY = 10'd0;
  logic [9:0] rom_addr;
  logic [3:0] rom_data = 4'h0;
  logic [3:0] index;
  logic       block_hit, out_valid;
  logic [9:0] BoxX, BoxY;

  typedef struct packed {logic v; logic h; logic [3:0] idx;} exp_t;
  exp_t       exp_q[$];
  logic [3:0] rom_mem [0:1023];
  int         checks = 0;
  int         errors = 0;
  int         bx, by, m_addr;
  box_state_t m_state;

  always #5 Clk = ~Clk;

  always @(posedge Clk) rom_data <= rom_mem[rom_addr];

  block_sprite_renderer dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .push_left(push_left),
    .push_right(push_right), .floor_below(floor_below), .pixel_valid(pixel_valid),
    .DrawX(DrawX), .DrawY(DrawY), .rom_addr(rom_addr), .rom_data(rom_data),
    .index(index), .block_hit(block_hit), .out_valid(out_valid), .BoxX(BoxX), .BoxY(BoxY)
  );

  // One pixel clock: check what the DUT produced, then drive the next pixel and push its expectation.
  task automatic cycle(input logic pv, input int x, input int y,
                       input logic tick, input logic pl, input logic pr, input logic fl);
    exp_t e;
    int   a;
    logic ins;
    @(negedge Clk);
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      checks++;
      if ({out_valid, block_hit, index} !== {e.v, e.h, e.idx}) begin
        errors++;
        $display("FAIL pixel: got v=%0b hit=%0b idx=%0h, want v=%0b hit=%0b idx=%0h",
                 out_valid, block_hit, index, e.v, e.h, e.idx);
      end
    end
    checks++;
    if (BoxX !== 10'(bx) || BoxY !== 10'(by)) begin
      errors++;
      $display("FAIL position: got (%0d,%0d), want (%0d,%0d)", BoxX, BoxY, bx, by);
    end
    checks++;
    if (rom_addr !== 10'(m_addr)) begin
      errors++;
      $display("FAIL rom_addr: got %0d, want %0d", rom_addr, m_addr);
    end
    checks++;
    if (dut.u_motion.state_r !== m_state) begin
      errors++;
      $display("FAIL state: got %0d, want %0d", dut.u_motion.state_r, m_state);
    end
    pixel_valid = pv; DrawX = 10'(x); DrawY = 10'(y);
    frame_tick = tick; push_left = pl; push_right = pr; floor_below = fl;
    ins = pv && (x >= bx) && (x < bx + 32) && (y >= by) && (y < by + 32);
    e = '{v: pv, h: 1'b0, idx: 4'h0};
    if (ins) begin
      a = (y - by) * 32 + (x - bx);
      m_addr = a;
      if (rom_mem[a] != 4'h6) begin
        e.h = 1'b1;
        e.idx = rom_mem[a];
      end
    end
    exp_q.push_back(e);
    if (tick) begin
      if (!fl) begin
        m_state = FALL;
        by = (by + 2 > 448) ? 448 : by + 2;
      end else if (pl ^ pr) begin
        if (pl) begin
          m_state = SLIDE_L;
          bx = (bx < 1) ? 0 : bx - 1;
        end else begin
          m_state = SLIDE_R;
          bx = (bx + 1 > 608) ? 608 : bx + 1;
        end
      end else begin
        m_state = REST;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic tick_n(input int n, input logic pl, input logic pr, input logic fl);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b1, pl, pr, fl);
  endtask

  // Reset asserted with a live pixel and a falling tick in the same cycle; reset must win.
  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1; pixel_valid = 1'b1; DrawX = 10'd310; DrawY = 10'd230;
    frame_tick = 1'b1; floor_below = 1'b0; push_left = 1'b0; push_right = 1'b1;
    @(negedge Clk);
    checks++;
    if ({out_valid, block_hit, index} !== 6'b0) begin
      errors++;
      $display("FAIL reset_out: got v=%0b hit=%0b idx=%0h, want 0 0 0", out_valid, block_hit, index);
    end
    checks++;
    if (BoxX !== 10'd304 || BoxY !== 10'd224 || rom_addr !== 10'd0) begin
      errors++;
      $display("FAIL reset_pos: got (%0d,%0d) addr %0d, want (304,224) addr 0", BoxX, BoxY, rom_addr);
    end
    Reset = 1'b0; pixel_valid = 1'b0; frame_tick = 1'b0; floor_below = 1'b1; push_right = 1'b0;
    exp_q.delete();
    exp_q.push_back('0);
    exp_q.push_back('0);
    bx = 304; by = 224; m_addr = 0; m_state = REST;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 300 + i, 224, 1'b0, 1'b0, 1'b0, 1'b1);
    tick_n(3, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 320, 240, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    idle(2);
  endtask

  task automatic test_pixel();
    rom_mem[65] = 4'h4;
    cycle(1'b1, 305, 226, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (rom_addr !== 10'd65) begin
      errors++;
      $display("FAIL addr65: got %0d, want 65", rom_addr);
    end
    cycle(1'b1, 304, 224, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 335, 255, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 310, 230, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
  endtask

  task automatic test_transparent();
    rom_mem[65] = 4'h6;
    cycle(1'b1, 305, 226, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 336, 226, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 303, 226, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 305, 256, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 305, 223, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
  endtask

  task automatic test_back_to_back();
    rom_mem[193] = 4'h9;
    cycle(1'b1, 303, 230, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 304, 230, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 305, 230, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
  endtask

  task automatic test_fall_slide();
    do_reset();
    tick_n(3, 1'b0, 1'b1, 1'b0);
    idle(1);
    checks++;
    if (BoxX !== 10'd304 || BoxY !== 10'd230) begin
      errors++;
      $display("FAIL fall3: got (%0d,%0d), want (304,230)", BoxX, BoxY);
    end
    tick_n(1, 1'b0, 1'b1, 1'b1);
    idle(1);
    checks++;
    if (BoxX !== 10'd305 || dut.u_motion.state_r !== SLIDE_R) begin
      errors++;
      $display("FAIL land_slide: got x=%0d st=%0d, want x=305 st=%0d", BoxX, dut.u_motion.state_r, SLIDE_R);
    end
    tick_n(130, 1'b0, 1'b0, 1'b0);
    idle(1);
    checks++;
    if (BoxY !== 10'd448) begin
      errors++;
      $display("FAIL y_clamp: got %0d, want 448", BoxY);
    end
    cycle(1'b1, 305, 479, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
  endtask

  task automatic test_clamp();
    do_reset();
    tick_n(303, 1'b1, 1'b0, 1'b1);
    idle(1);
    checks++;
    if (BoxX !== 10'd1) begin
      errors++;
      $display("FAIL x_one: got %0d, want 1", BoxX);
    end
    tick_n(3, 1'b1, 1'b0, 1'b1);
    idle(1);
    checks++;
    if (BoxX !== 10'd0) begin
      errors++;
      $display("FAIL x_left_clamp: got %0d, want 0", BoxX);
    end
    tick_n(2, 1'b1, 1'b1, 1'b1);
    idle(1);
    checks++;
    if (BoxX !== 10'd0 || dut.u_motion.state_r !== REST) begin
      errors++;
      $display("FAIL both_push: got x=%0d st=%0d, want x=0 st=%0d", BoxX, dut.u_motion.state_r, REST);
    end
    cycle(1'b1, 0, 224, 1'b0, 1'b0, 1'b0, 1'b1);
    tick_n(620, 1'b0, 1'b1, 1'b1);
    idle(1);
    checks++;
    if (BoxX !== 10'd608) begin
      errors++;
      $display("FAIL x_right_clamp: got %0d, want 608", BoxX);
    end
    tick_n(120, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 639, 479, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 608, 448, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 607, 460, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom_mem[i] = 4'($urandom_range(0, 15));
    rom_mem[1023] = 4'hA;
    rom_mem[0] = 4'h3;
    test_reset();
    test_pixel();
    test_transparent();
    test_back_to_back();
    test_fall_slide();
    test_clamp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
